// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: select codes, ALUOp codes, FSM states.
package alu_ctrl_pkg;

  localparam logic [4:0] SEL_ADD     = 5'b0_0000;
  localparam logic [4:0] SEL_SUB     = 5'b0_0001;
  localparam logic [4:0] SEL_LUI     = 5'b0_0011;
  localparam logic [4:0] SEL_OR      = 5'b0_0100;
  localparam logic [4:0] SEL_AND     = 5'b0_0101;
  localparam logic [4:0] SEL_XOR     = 5'b0_0111;
  localparam logic [4:0] SEL_SLL     = 5'b0_1000;
  localparam logic [4:0] SEL_SRL     = 5'b0_1001;
  localparam logic [4:0] SEL_SRA     = 5'b0_1010;
  localparam logic [4:0] SEL_SLT     = 5'b0_1101;
  localparam logic [4:0] SEL_SLTU    = 5'b0_1111;
  localparam logic [4:0] SEL_M_BASE  = 5'b1_0000;
  localparam logic [4:0] ILLEGAL_SEL = 5'b0_1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-side handshake and EX-side output bundle of the ALU control stage.
interface alu_ctrl_seq_if #(
  parameter int SEL_W = 5
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [31:0]      instr;
  logic             alu_src;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             illegal;
  logic             m_busy;

  modport master (
    output flush, in_valid, alu_op, instr, alu_src, out_ready,
    input  in_ready, out_valid, sel, illegal, m_busy
  );

  modport slave (
    input  flush, in_valid, alu_op, instr, alu_src, out_ready,
    output in_ready, out_valid, sel, illegal, m_busy
  );
endinterface

// File: rtl/alu_sel_decode.sv
// Combinational ALUOp/funct decode to ALU select code, with RV32M classification.
module alu_sel_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W    = 5,
  parameter int ENABLE_M = 1
) (
  input  logic [1:0]       alu_op,
  input  logic [31:0]      instr,
  input  logic             alu_src,
  output logic [SEL_W-1:0] sel,
  output logic             illegal,
  output logic             is_m,
  output logic             is_div
);

  logic [2:0] f3;
  logic       alt;
  logic       m_enc;
  logic [4:0] sel5;
  logic       unused_instr_bits;

  assign f3    = instr[14:12];
  assign alt   = instr[30] && !alu_src;
  assign m_enc = !alu_src && instr[25] && !instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:0]};

  // Select-code table; M encodings win over the base funct3 table.
  always_comb begin
    sel5    = SEL_ADD;
    illegal = 1'b0;
    is_m    = 1'b0;
    is_div  = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: sel5 = SEL_ADD;
      ALUOP_SUB: sel5 = SEL_SUB;
      ALUOP_LUI: sel5 = SEL_LUI;
      default: begin
        if (m_enc) begin
          if (ENABLE_M != 0) begin
            is_m   = 1'b1;
            is_div = f3[2];
            sel5   = SEL_M_BASE | {2'b00, f3};
          end else begin
            illegal = 1'b1;
          end
        end else begin
          unique case (f3)
            3'b000: sel5 = alt ? SEL_SUB : SEL_ADD;
            3'b111: begin sel5 = SEL_AND;  illegal = alt; end
            3'b110: begin sel5 = SEL_OR;   illegal = alt; end
            3'b100: begin sel5 = SEL_XOR;  illegal = alt; end
            3'b010: begin sel5 = SEL_SLT;  illegal = alt; end
            3'b011: begin sel5 = SEL_SLTU; illegal = alt; end
            3'b001: begin sel5 = SEL_SLL;  illegal = instr[30]; end
            default: sel5 = instr[30] ? SEL_SRA : SEL_SRL;
          endcase
        end
      end
    endcase
    if (illegal) sel5 = ILLEGAL_SEL;
  end

  assign sel = SEL_W'(sel5);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control stage with a multi-cycle RV32M sequencer.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W      = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int ENABLE_M   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_seq_if.slave    bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             illegal_q, illegal_d;
  logic             m_busy_q, m_busy_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal;
  logic             dec_is_m;
  logic             dec_is_div;
  logic [CNT_W-1:0] op_n;
  logic             multi;
  logic             in_ready;
  logic             accept;

  alu_sel_decode #(
    .SEL_W    (SEL_W),
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .alu_op  (bus.alu_op),
    .instr   (bus.instr),
    .alu_src (bus.alu_src),
    .sel     (dec_sel),
    .illegal (dec_illegal),
    .is_m    (dec_is_m),
    .is_div  (dec_is_div)
  );

  assign op_n  = dec_is_div ? DIV_N : MUL_N;
  assign multi = dec_is_m && (op_n != ONE);

  // rst_n gates readiness so nothing looks acceptable while reset is held.
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // Next-state: flush beats everything; BUSY releases the held M code at cnt==1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    illegal_d   = illegal_q;
    m_busy_d    = m_busy_q;
    pend_sel_d  = pend_sel_q;
    if (bus.flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      m_busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (multi) begin
              state_d     = BUSY;
              cnt_d       = op_n - ONE;
              m_busy_d    = 1'b1;
              out_valid_d = 1'b0;
              pend_sel_d  = dec_sel;
            end else begin
              out_valid_d = 1'b1;
              sel_d       = dec_sel;
              illegal_d   = dec_illegal;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q == ONE) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            sel_d       = pend_sel_q;
            illegal_d   = 1'b0;
            m_busy_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      illegal_q   <= 1'b0;
      m_busy_q    <= 1'b0;
      pend_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      illegal_q   <= illegal_d;
      m_busy_q    <= m_busy_d;
      pend_sel_q  <= pend_sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.m_busy    = m_busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: one ENABLE_M=1 and one ENABLE_M=0 instance share stimulus.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [31:0] instr;
  logic        alu_src;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.SEL_W(5)) bus_a ();
  alu_ctrl_seq_if #(.SEL_W(5)) bus_b ();

  assign bus_a.flush = flush;     assign bus_b.flush = flush;
  assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
  assign bus_a.alu_op = alu_op;   assign bus_b.alu_op = alu_op;
  assign bus_a.instr = instr;     assign bus_b.instr = instr;
  assign bus_a.alu_src = alu_src; assign bus_b.alu_src = alu_src;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

  alu_ctrl_seq #(.SEL_W(5), .MUL_CYCLES(2), .DIV_CYCLES(32), .ENABLE_M(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  alu_ctrl_seq #(.SEL_W(5), .MUL_CYCLES(2), .DIV_CYCLES(32), .ENABLE_M(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: mnemonic-level rules, latency in cycles from the accepting cycle.
  function automatic void ref_decode(input logic [1:0] op, input logic [31:0] ins,
                                     input logic src, input bit en_m,
                                     output bit ill, output logic [4:0] s, output int lat);
    logic [2:0] f3;
    bit is_sub_form;
    f3 = ins[14:12];
    is_sub_form = ins[30] && !src;
    ill = 0; s = 5'd0; lat = 1;
    if (op == 2'd0) s = 5'd0;
    else if (op == 2'd1) s = 5'd1;
    else if (op == 2'd3) s = 5'd3;
    else if (!src && ins[25] && !ins[30]) begin
      if (en_m) begin
        s = 5'd16 + {2'b00, f3};
        lat = f3[2] ? 32 : 2;
      end else ill = 1;
    end else begin
      case (f3)
        3'd0: s = is_sub_form ? 5'd1 : 5'd0;
        3'd7: begin s = 5'd5;  ill = is_sub_form; end
        3'd6: begin s = 5'd4;  ill = is_sub_form; end
        3'd4: begin s = 5'd7;  ill = is_sub_form; end
        3'd2: begin s = 5'd13; ill = is_sub_form; end
        3'd3: begin s = 5'd15; ill = is_sub_form; end
        3'd1: begin s = 5'd8;  ill = ins[30]; end
        default: s = ins[30] ? 5'd10 : 5'd9;
      endcase
    end
    if (ill) s = 5'd15;
  endfunction

  // Transaction-level model state per instance (0: M enabled, 1: M disabled).
  bit         m_ov[2];
  bit         m_ill[2];
  bit         m_busy[2];
  logic [4:0] m_sel[2];
  logic [4:0] m_psel[2];
  int         m_done[2];

  function automatic bit exp_ready(input int i);
    return rst_n && !m_busy[i] && (!m_ov[i] || out_ready) && !flush;
  endfunction

  initial begin
    for (int unsigned i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_ill[i] = 0; m_busy[i] = 0; m_sel[i] = '0; m_psel[i] = '0; m_done[i] = 0;
    end
  end

  // Model advance at every rising edge from the inputs held across that edge.
  always @(posedge clk) begin
    bit ill; logic [4:0] s; int lat; bit acc;
    cyc++;
    for (int unsigned i = 0; i < 2; i++) begin
      acc = in_valid && exp_ready(i);
      ref_decode(alu_op, instr, alu_src, (i == 0), ill, s, lat);
      if (!rst_n) begin
        m_ov[i] = 0; m_ill[i] = 0; m_busy[i] = 0; m_sel[i] = '0; m_psel[i] = '0;
      end else if (flush) begin
        m_ov[i] = 0; m_busy[i] = 0;
      end else if (m_busy[i]) begin
        if (cyc == m_done[i]) begin
          m_busy[i] = 0; m_ov[i] = 1; m_sel[i] = m_psel[i]; m_ill[i] = 0;
        end
      end else if (acc) begin
        if (lat == 1) begin
          m_ov[i] = 1; m_sel[i] = s; m_ill[i] = ill;
        end else begin
          m_ov[i] = 0; m_busy[i] = 1; m_psel[i] = s; m_done[i] = cyc + lat - 1;
        end
      end else if (m_ov[i] && out_ready) begin
        m_ov[i] = 0;
      end
    end
  end

  task automatic check_inst(input int i, input logic ov, input logic [4:0] s, input logic ill,
                            input logic busy, input logic rdy);
    string p;
    p = (i == 0) ? "A" : "B";
    chk({p, ".out_valid"}, ov, m_ov[i]);
    chk({p, ".sel"}, s, m_sel[i]);
    chk({p, ".illegal"}, ill, m_ill[i]);
    chk({p, ".m_busy"}, busy, m_busy[i]);
    chk({p, ".in_ready"}, rdy, exp_ready(i));
  endtask

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, bus_a.out_valid, bus_a.sel, bus_a.illegal, bus_a.m_busy, bus_a.in_ready);
      check_inst(1, bus_b.out_valid, bus_b.sel, bus_b.illegal, bus_b.m_busy, bus_b.in_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic b30,
                        input logic b25, input logic src);
    alu_op  = op;
    instr   = 32'h0000_0033;
    instr[14:12] = f3;
    instr[30] = b30;
    instr[25] = b25;
    alu_src = src;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int busy_cnt;
    int ov_cnt;
    rst_n = 0; flush = 0; in_valid = 1; out_ready = 1;
    set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with in_valid high.
    for (int unsigned i = 0; i < 2; i++) begin
      step();
      chk_en = 1;
      chk("rst.out_valid", bus_a.out_valid, 1'b0);
      chk("rst.m_busy", bus_a.m_busy, 1'b0);
      chk("rst.in_ready", bus_a.in_ready, 1'b0);
      chk("rst.sel", bus_a.sel, 5'b00000);
    end

    // Back-to-back SUB stream.
    rst_n = 1;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      chk("sub.out_valid", bus_a.out_valid, 1'b1);
      chk("sub.sel", bus_a.sel, 5'b00001);
    end
    in_valid = 0;
    step();
    chk("sub.drain", bus_a.out_valid, 1'b0);

    // DIV latency.
    set_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b0);
    in_valid = 1;
    step();
    in_valid = 0;
    k = 1; busy_cnt = 0;
    chk("div.in_ready_busy", bus_a.in_ready, 1'b0);
    if (bus_a.m_busy) busy_cnt++;
    while (!bus_a.out_valid && k < 100) begin
      step();
      k++;
      if (bus_a.m_busy) busy_cnt++;
    end
    chk("div.latency", k, 32);
    chk("div.busy_cycles", busy_cnt, 31);
    chk("div.sel", bus_a.sel, 5'b10100);
    step();

    // MUL latency.
    set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    in_valid = 1;
    step();
    in_valid = 0;
    k = 1;
    while (!bus_a.out_valid && k < 100) begin
      step();
      k++;
    end
    chk("mul.latency", k, 2);
    chk("mul.sel", bus_a.sel, 5'b10000);
    step();

    // Output hold under backpressure, then consume+accept in one cycle.
    out_ready = 0;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    in_valid = 1;
    step();
    set_op(2'b10, 3'b100, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("hold.out_valid", bus_a.out_valid, 1'b1);
      chk("hold.sel", bus_a.sel, 5'b00000);
      chk("hold.in_ready", bus_a.in_ready, 1'b0);
      step();
    end
    out_ready = 1;
    step();
    chk("hold.next_sel", bus_a.sel, 5'b00111);
    chk("hold.next_valid", bus_a.out_valid, 1'b1);
    in_valid = 0;
    step();
    chk("hold.consumed", bus_a.out_valid, 1'b0);

    // Flush at cycle 10 of a DIV.
    set_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b0);
    in_valid = 1;
    step();
    in_valid = 0;
    for (int unsigned i = 0; i < 9; i++) step();
    flush = 1;
    in_valid = 1;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush.in_ready", bus_a.in_ready, 1'b0);
    step();
    flush = 0;
    chk("flush.m_busy", bus_a.m_busy, 1'b0);
    chk("flush.out_valid", bus_a.out_valid, 1'b0);
    step();
    in_valid = 0;
    chk("flush.add_valid", bus_a.out_valid, 1'b1);
    chk("flush.add_sel", bus_a.sel, 5'b00000);
    ov_cnt = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      step();
      if (bus_a.out_valid) ov_cnt++;
    end
    chk("flush.no_div_out", ov_cnt, 0);

    // M disabled: MULHU illegal in one cycle; SLL with instr[30] illegal on both.
    set_op(2'b10, 3'b011, 1'b0, 1'b1, 1'b0);
    in_valid = 1;
    step();
    chk("nom.mulhu_valid", bus_b.out_valid, 1'b1);
    chk("nom.mulhu_illegal", bus_b.illegal, 1'b1);
    chk("nom.mulhu_sel", bus_b.sel, 5'b01111);
    in_valid = 0;
    for (int unsigned i = 0; i < 3; i++) step();
    set_op(2'b10, 3'b001, 1'b1, 1'b0, 1'b0);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("sll30.illegal_b", bus_b.illegal, 1'b1);
    chk("sll30.sel_b", bus_b.sel, 5'b01111);
    chk("sll30.illegal_a", bus_a.illegal, 1'b1);
    step();

    // Randomized traffic checked by the model.
    for (int unsigned i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(199) != 0);
      flush     = ($urandom_range(39) == 0);
      in_valid  = ($urandom_range(9) < 6);
      out_ready = ($urandom_range(9) < 7);
      alu_op    = 2'($urandom_range(3));
      instr     = $urandom;
      if ($urandom_range(1) == 1) begin
        instr[25] = 1'b1;
        instr[30] = 1'b0;
      end
      alu_src   = ($urandom_range(3) == 0);
      step();
    end

    rst_n = 1; flush = 0; in_valid = 0; out_ready = 1;
    step();
    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
